// File: rtl/song_nav_controller.sv
// Three-button song navigator: per-button debounce/auto-repeat FSMs feed a
// registered song index, pause flag and one-cycle song-change pulse.
module song_nav_controller #(
  parameter int unsigned N_SONGS      = 4,
  parameter int unsigned SONG_W       = 2,
  parameter logic [24:0] GAP          = 25'd1_000_000,
  parameter logic [24:0] REPEAT_DELAY = 25'd20_000_000,
  parameter logic [24:0] REPEAT_RATE  = 25'd5_000_000,
  parameter bit          WRAP         = 1'b1,
  parameter logic [2:0]  PLAY_MODE    = 3'b011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        mode,
  input  logic [2:0]        button,
  output logic              pause,
  output logic [SONG_W-1:0] song_num,
  output logic              song_changed
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} btn_state_t;

  localparam logic [24:0]       RATE_LAST = REPEAT_RATE - 25'd1;
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(N_SONGS - 1);

  logic              active;
  logic [2:0]        btn_event;
  logic [SONG_W-1:0] song_q, song_d;
  logic              pause_q, pause_d;
  logic              changed_q, changed_d;
  logic              step_up, step_dn;

  assign active = (mode == PLAY_MODE);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      // The pause button (index 1) fires once per press and never repeats.
      localparam bit CAN_REPEAT = (gi != 1);

      btn_state_t  state_q;
      logic [24:0] cnt_q;
      logic        ev;

      always_comb begin
        ev = 1'b0;
        if (active && button[gi]) begin
          case (state_q)
            DEBOUNCE: ev = (cnt_q == GAP);
            HELD:     ev = CAN_REPEAT && (cnt_q == REPEAT_DELAY);
            REPEAT:   ev = CAN_REPEAT && (cnt_q == RATE_LAST);
            default:  ev = 1'b0;
          endcase
        end
      end

      assign btn_event[gi] = ev;

      always_ff @(posedge clk) begin
        if (!rst_n || !active || !button[gi]) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          case (state_q)
            IDLE: begin
              state_q <= DEBOUNCE;
              cnt_q   <= 25'd1;
            end
            DEBOUNCE: begin
              if (cnt_q >= GAP) begin
                state_q <= HELD;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 25'd1;
              end
            end
            HELD: begin
              if (!CAN_REPEAT) begin
                cnt_q <= '0;
              end else if (cnt_q >= REPEAT_DELAY) begin
                state_q <= REPEAT;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 25'd1;
              end
            end
            REPEAT: begin
              if (cnt_q >= RATE_LAST) cnt_q <= '0;
              else                    cnt_q <= cnt_q + 25'd1;
            end
            default: begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // Simultaneous previous and next cancel; a real index change overrides pause.
  always_comb begin
    song_d    = song_q;
    pause_d   = pause_q;
    changed_d = 1'b0;
    step_up   = btn_event[2] && !btn_event[0];
    step_dn   = btn_event[0] && !btn_event[2];
    if (step_up) begin
      if (song_q >= LAST_SONG) song_d = WRAP ? '0 : LAST_SONG;
      else                     song_d = song_q + SONG_W'(1);
    end else if (step_dn) begin
      if (song_q == '0)        song_d = WRAP ? LAST_SONG : '0;
      else                     song_d = song_q - SONG_W'(1);
    end
    if (song_d != song_q) begin
      changed_d = 1'b1;
      pause_d   = 1'b0;
    end else if (btn_event[1]) begin
      pause_d = !pause_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      song_q    <= '0;
      pause_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      song_q    <= song_d;
      pause_q   <= pause_d;
      changed_q <= changed_d;
    end
  end

  assign song_num     = song_q;
  assign pause        = pause_q;
  assign song_changed = changed_q;

endmodule
